// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes and sequencer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD_A,
    LOAD_B,
    WAIT,
    RESULT
  } seq_state_t;

  // States in which the ALU is working on a command and must see its opcode.
  function automatic logic alu_busy(seq_state_t s);
    return (s == CLEAR) || (s == LOAD_A) || (s == LOAD_B) || (s == WAIT);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: first-word fall-through synchronous FIFO holding {op, A, B} words.
// Latency: a word pushed at edge t is visible on dout_o from t (one edge to reach the head).
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/count.
module alu_cmd_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array: written at the tail, no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Occupancy next-state: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds buffered {op,A,B} commands to an 8-bit sequential ALU and returns its results.
// Latency: push into empty FIFO at edge t -> res_valid from edge t+4+ALU_LAT.
// Backpressure: cmd_ready drops when the FIFO is full; no new command starts until the result is taken.
// Optional: define ALU_SEQ_CNT_EN to add the 16-bit op_count port (completed result handshakes).
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int BUS_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = 8
) (
  input  logic             CLk,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [BUS_W-1:0] cmd_a,
  input  logic [BUS_W-1:0] cmd_b,
  output logic [BUS_W-1:0] alu_inbus,
  output logic [1:0]       alu_op,
  output logic             alu_begin,
  output logic             alu_rst,
  input  logic [BUS_W-1:0] alu_outbus,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [BUS_W-1:0] res_data,
  output logic [1:0]       res_op
`ifdef ALU_SEQ_CNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int CMD_W = 2 + 2 * BUS_W;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int LW    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

  seq_state_t       state_q, state_d;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             push, pop;
  logic             unused_fifo_full;

  logic [1:0]       cur_op_q;
  logic [BUS_W-1:0] cur_a_q, cur_b_q;
  logic [LW-1:0]    wait_cnt_q;
  logic             res_valid_q;
  logic [BUS_W-1:0] res_data_q;
  logic [1:0]       res_op_q;
  logic             wait_done, res_hs;

  // Acceptance is decided from occupancy alone, so a full FIFO never passes a command through
  // even when the head is popped in the same cycle.
  assign cmd_ready        = !RST && (fifo_count != FIFO_FULL_CNT);
  assign push             = cmd_valid && cmd_ready;
  assign pop              = (state_q == IDLE) && !fifo_empty;
  assign unused_fifo_full = fifo_full;
  assign wait_done        = (state_q == WAIT) && (wait_cnt_q == '0);
  assign res_hs           = res_valid_q && res_ready;

  alu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLk),
    .rst_i   (RST),
    .push_i  (push),
    .din_i   ({cmd_op, cmd_a, cmd_b}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge CLk) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: one command at a time, result must be taken before the next pop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = CLEAR;
      CLEAR:   state_d = LOAD_A;
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = WAIT;
      WAIT:    if (wait_cnt_q == '0) state_d = RESULT;
      RESULT:  if (res_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: drive the ALU's shared bus and its begin/clear protocol.
  always_comb begin
    alu_rst   = RST || (state_q == CLEAR);
    alu_begin = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == WAIT);
    alu_op    = alu_busy(state_q) ? cur_op_q : 2'd0;
    alu_inbus = '0;
    if (state_q == LOAD_A) alu_inbus = cur_a_q;
    if (state_q == LOAD_B) alu_inbus = cur_b_q;
  end

  // Datapath: latch the popped command, count down the ALU latency, capture and hold the result.
  always_ff @(posedge CLk) begin
    if (RST) begin
      cur_op_q    <= '0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      wait_cnt_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      if (pop) begin
        {cur_op_q, cur_a_q, cur_b_q} <= fifo_dout;
      end
      if (state_q == LOAD_B) begin
        wait_cnt_q <= LW'(ALU_LAT - 1);
      end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
        wait_cnt_q <= wait_cnt_q - LW'(1);
      end
      if (wait_done) begin
        res_valid_q <= 1'b1;
        res_data_q  <= alu_outbus;
        res_op_q    <= cur_op_q;
      end else if (res_hs) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

`ifdef ALU_SEQ_CNT_EN
  logic [15:0] op_count_q;

  // Completed-operation counter, advanced on every result handshake and wrapping at 2^16.
  always_ff @(posedge CLk) begin
    if (RST)         op_count_q <= '0;
    else if (res_hs) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count = op_count_q;
`endif

endmodule
